// File: rtl/hazard_scoreboard_v_pkg.sv
// Shared pipeline definitions for the hazard scoreboard.
// Holds the forward-select encodings seen by the EX operand muxes and a
// constant-evaluable ceil(log2) used to size the per-register countdowns.
package hazard_scoreboard_v_pkg;

    // EX operand source encodings (value k = output of post-EX stage k)
    localparam logic [1:0] FWD_NONE  = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    // ceil(log2(v)); returns 0 for v <= 1
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < v) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sb_entry_v.sv
// One scoreboard entry: tracks the pending write to a single architectural
// register as a countdown plus a "producer is a load" flag.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   issue_i      - an instruction writing this register issues this cycle
//   issue_ld_i   - that issuing instruction is a load
//   hazard_o     - a consumer in ID reading this register must stall
//   fwd_o        - forward select a consumer in ID would need in EX
module sb_entry_v
    import hazard_scoreboard_v_pkg::*;
#(
    parameter int D          = 2,
    parameter int LOAD_STAGE = 2,
    parameter int FORW_ON    = 1,
    parameter int CW         = 2,
    parameter int FW         = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_i,
    input  logic          issue_ld_i,
    output logic          hazard_o,
    output logic [FW-1:0] fwd_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ld_q, ld_d;
    logic          active_s;
    logic [FW-1:0] dist_s;

    // Issue reloads the countdown (youngest producer wins), otherwise count down
    always_comb begin
        cnt_d = cnt_q;
        ld_d  = ld_q;
        if (issue_i) begin
            cnt_d = CW'(D + 1);
            ld_d  = issue_ld_i;
        end else if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Countdown and load-flag state
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
            ld_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ld_q  <= ld_d;
        end
    end

    // cnt == 1 is the regfile write cycle; the regfile is write-first, so only
    // cnt >= 2 needs forwarding or stalling. dist = stage the producer will
    // occupy while the consumer sits in EX.
    always_comb begin
        active_s = (cnt_q >= CW'(2));
        dist_s   = {FW{1'b0}};
        hazard_o = 1'b0;
        fwd_o    = FW'(FWD_NONE);
        if (active_s) begin
            dist_s = FW'(D + 2 - int'(cnt_q));
            if (FORW_ON != 0) begin
                hazard_o = ld_q && (int'(dist_s) < LOAD_STAGE);
                fwd_o    = dist_s;
            end else begin
                hazard_o = 1'b1;
                fwd_o    = FW'(FWD_NONE);
            end
        end else begin
            dist_s   = {FW{1'b0}};
            hazard_o = 1'b0;
            fwd_o    = FW'(FWD_NONE);
        end
    end

endmodule

// File: rtl/hazard_scoreboard_v.sv
// Data-hazard unit beside the ID stage using a per-register countdown
// scoreboard. Decides the ID stall, registers EX forward selects and counts
// stall cycles.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   id_valid                 - ID holds a valid instruction
//   id_rs1/id_rs2            - ID source registers
//   id_use_rs1/id_use_rs2    - instruction reads the source
//   id_rd, id_regWrite       - destination and write enable
//   id_memRead               - instruction is a load
//   is_flush                 - squash the ID instruction this cycle
//   stall                    - combinational: hold PC/IF-ID, bubble ID/EX
//   ex_forwA/ex_forwB        - registered EX operand sources (0 = ID/EX)
//   stall_cycles             - saturating count of stall cycles
module hazard_scoreboard_v
    import hazard_scoreboard_v_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int RADDR_W    = 5,
    parameter int D          = 2,
    parameter int LOAD_STAGE = 2,
    parameter int FORW_ON    = 1,
    parameter int FW         = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_regWrite,
    input  logic               id_memRead,
    input  logic               is_flush,
    output logic               stall,
    output logic [FW-1:0]      ex_forwA,
    output logic [FW-1:0]      ex_forwB,
    output logic [31:0]        stall_cycles
);

    localparam int CW = clog2(D + 2);

    logic          haz_s [NUM_REGS];
    logic [FW-1:0] fwd_s [NUM_REGS];

    logic          hazard_rs1_s, hazard_rs2_s;
    logic [FW-1:0] sel_a_s, sel_b_s;
    logic          stall_s, iss_s;

    logic [FW-1:0] ex_forwA_q, ex_forwA_d;
    logic [FW-1:0] ex_forwB_q, ex_forwB_d;
    logic [31:0]   stall_cycles_q, stall_cycles_d;

    // x0 is hardwired: never a hazard, never forwarded
    assign haz_s[0] = 1'b0;
    assign fwd_s[0] = FW'(FWD_NONE);

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
            sb_entry_v #(
                .D          (D),
                .LOAD_STAGE (LOAD_STAGE),
                .FORW_ON    (FORW_ON),
                .CW         (CW),
                .FW         (FW)
            ) u_entry (
                .clk        (clk),
                .reset      (reset),
                .issue_i    (iss_s && id_regWrite && (id_rd == RADDR_W'(r))),
                .issue_ld_i (id_memRead),
                .hazard_o   (haz_s[r]),
                .fwd_o      (fwd_s[r])
            );
        end
    endgenerate

    // Select the entry state of each used, nonzero source register
    always_comb begin
        hazard_rs1_s = 1'b0;
        hazard_rs2_s = 1'b0;
        sel_a_s      = FW'(FWD_NONE);
        sel_b_s      = FW'(FWD_NONE);
        if (id_use_rs1 && (id_rs1 != {RADDR_W{1'b0}})) begin
            hazard_rs1_s = haz_s[id_rs1];
            sel_a_s      = fwd_s[id_rs1];
        end else begin
            hazard_rs1_s = 1'b0;
            sel_a_s      = FW'(FWD_NONE);
        end
        if (id_use_rs2 && (id_rs2 != {RADDR_W{1'b0}})) begin
            hazard_rs2_s = haz_s[id_rs2];
            sel_b_s      = fwd_s[id_rs2];
        end else begin
            hazard_rs2_s = 1'b0;
            sel_b_s      = FW'(FWD_NONE);
        end
    end

    // A squashed instruction never waits, so flush masks the stall
    assign stall_s = id_valid && !is_flush && (hazard_rs1_s || hazard_rs2_s);
    assign iss_s   = id_valid && !stall_s && !is_flush;

    // Next forward selects and saturating stall counter
    always_comb begin
        ex_forwA_d     = FW'(FWD_NONE);
        ex_forwB_d     = FW'(FWD_NONE);
        stall_cycles_d = stall_cycles_q;
        if (iss_s) begin
            ex_forwA_d = sel_a_s;
            ex_forwB_d = sel_b_s;
        end else begin
            ex_forwA_d = FW'(FWD_NONE);
            ex_forwB_d = FW'(FWD_NONE);
        end
        if (stall_s && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // Forward-select and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_forwA_q     <= FW'(FWD_NONE);
            ex_forwB_q     <= FW'(FWD_NONE);
            stall_cycles_q <= 32'd0;
        end else begin
            ex_forwA_q     <= ex_forwA_d;
            ex_forwB_q     <= ex_forwB_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall        = stall_s;
    assign ex_forwA     = ex_forwA_q;
    assign ex_forwB     = ex_forwB_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard_v.sv
// Directed, table-driven bench for hazard_scoreboard_v (default parameters)
// plus a second instance with forwarding disabled.
module tb_hazard_scoreboard_v;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic        id_regWrite, id_memRead, is_flush;
    logic        stall, nf_stall;
    logic [1:0]  ex_forwA, ex_forwB, nf_forwA, nf_forwB;
    logic [31:0] stall_cycles, nf_stall_cycles;

    int tests = 0;
    int fails = 0;

    hazard_scoreboard_v dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .is_flush(is_flush), .stall(stall),
        .ex_forwA(ex_forwA), .ex_forwB(ex_forwB), .stall_cycles(stall_cycles)
    );

    hazard_scoreboard_v #(.FORW_ON(0)) dut_nf (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .is_flush(is_flush), .stall(nf_stall),
        .ex_forwA(nf_forwA), .ex_forwB(nf_forwB), .stall_cycles(nf_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       fl;
        logic       e_stall;
        logic [1:0] e_fa;
        logic [1:0] e_fb;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic v, input logic [4:0] r1, input logic u1,
                                input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                                input logic rw, input logic mr, input logic fl,
                                input logic es, input logic [1:0] fa, input logic [1:0] fb);
        vec_t t;
        t.valid = v; t.rs1 = r1; t.u1 = u1; t.rs2 = r2; t.u2 = u2; t.rd = rd;
        t.rw = rw; t.mr = mr; t.fl = fl; t.e_stall = es; t.e_fa = fa; t.e_fb = fb;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.valid; id_rs1 = v.rs1; id_use_rs1 = v.u1;
        id_rs2 = v.rs2; id_use_rs2 = v.u2; id_rd = v.rd;
        id_regWrite = v.rw; id_memRead = v.mr; is_flush = v.fl;
    endtask

    // drive, check stall before the edge, check forward registers after it
    task automatic apply(input vec_t v, input string nm);
        drive(v);
        #1;
        chk({nm, " stall"}, 32'(stall), 32'(v.e_stall));
        @(posedge clk);
        #1;
        chk({nm, " forwA"}, 32'(ex_forwA), 32'(v.e_fa));
        chk({nm, " forwB"}, 32'(ex_forwB), 32'(v.e_fb));
    endtask

    task automatic do_reset();
        drive(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        //              v     rs1  u1    rs2  u2    rd    rw    mr    fl    st    fa    fb
        tbl[0]  = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0); // add x5
        tbl[1]  = mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0); // read x5 dist1
        tbl[2]  = mk(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2); // dist2
        tbl[3]  = mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0); // WB cycle
        tbl[4]  = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0); // lw x6
        tbl[5]  = mk(1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0); // load-use
        tbl[6]  = mk(1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2); // retry
        tbl[7]  = mk(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1); // read x7
        tbl[8]  = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0); // add x5
        tbl[9]  = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0); // lw x5
        tbl[10] = mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0); // youngest wins
        tbl[11] = mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0);
        tbl[12] = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0); // lw x0
        tbl[13] = mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0); // read x0
        tbl[14] = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0); // lw x8
        tbl[15] = mk(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0); // flushed
        tbl[16] = mk(1'b1, 5'd9, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2); // x9 clean

        reset = 1'b1;
        drive(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset forwA", 32'(ex_forwA), 32'd0);
        chk("reset forwB", 32'(ex_forwB), 32'd0);
        chk("reset stall_cycles", stall_cycles, 32'd0);

        for (int i = 0; i < 17; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end
        chk("stall_cycles after table", stall_cycles, 32'd2);

        // reset with three pending loads and a stalled consumer
        apply(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0), "lw x10");
        apply(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0), "lw x11");
        apply(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0), "lw x12");
        drive(mk(1'b1, 5'd12, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        reset = 1'b1;
        #1;
        chk("pre-reset stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("post-reset stall", 32'(stall), 32'd0);
        chk("post-reset stall_cycles", stall_cycles, 32'd0);
        chk("post-reset forwA", 32'(ex_forwA), 32'd0);
        @(posedge clk);
        #1;
        chk("post-reset issue forwA", 32'(ex_forwA), 32'd0);
        chk("post-reset issue forwB", 32'(ex_forwB), 32'd0);

        // counter saturation from a preloaded value
        drive(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_q;
        @(posedge clk);
        #1;
        apply(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0), "lw x20");
        apply(mk(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0), "use x20");
        chk("sat reaches max", stall_cycles, 32'hFFFF_FFFF);
        apply(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0), "lw x21");
        apply(mk(1'b1, 5'd21, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0), "use x21");
        chk("sat holds max", stall_cycles, 32'hFFFF_FFFF);

        // forwarding disabled: consumer waits for the regfile write
        do_reset();
        drive(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        @(posedge clk);
        #1;
        drive(mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        #1;
        chk("nf stall c1", 32'(nf_stall), 32'd1);
        @(posedge clk);
        #1;
        chk("nf stall c2", 32'(nf_stall), 32'd1);
        chk("nf bubble forwA", 32'(nf_forwA), 32'd0);
        @(posedge clk);
        #1;
        chk("nf stall c3", 32'(nf_stall), 32'd0);
        @(posedge clk);
        #1;
        chk("nf issue forwA", 32'(nf_forwA), 32'd0);
        chk("nf stall_cycles", nf_stall_cycles, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
